key_event: RTL
==============

Name: key_event

Overview:
- Downstream consumer of the debounced push-button level produced by the team's 8-sample debouncer (sampled on the 1 ms clock).
- Converts that clean level into single-cycle event pulses in the system clock domain: press, release, long-press and auto-repeat.
- Feeds counters, menu FSMs and display logic, so no other block needs to edge-detect button levels.

Parameters:
- LONG_MS, 1000, number of tick_1ms pulses held before long_press fires.
- REPEAT_MS, 200, tick_1ms pulses between successive repeat pulses once long-press is reached.
- CNT_W, 16, tick counter width; must satisfy 2^CNT_W > max(LONG_MS, REPEAT_MS). Both ms parameters must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- tick_1ms, input, 1, one-clk-wide enable pulse every 1 ms from the clock divider, synchronous to clk.
- btn_in, input, 1, debounced button level (1 = pressed); asynchronous to clk.
- press, output, 1, one-cycle pulse on a press.
- release, output, 1, one-cycle pulse on a release.
- long_press, output, 1, one-cycle pulse when the hold reaches LONG_MS.
- repeat_evt, output, 1, one-cycle pulse every REPEAT_MS while in long hold.
- held, output, 1, level: button is considered pressed (state != IDLE).

Behaviour:
- Reset (async assert, sync release by clk edge):
  - Sync flops, edge register, counter = 0; state = IDLE.
  - All outputs = 0.
- Input path:
  - btn_in passes through a 2-flop synchronizer to give btn_s.
  - btn_d is btn_s delayed one clk.
  - rise = btn_s & ~btn_d; fall = ~btn_s & btn_d.
- Outputs are registered.
  - press/release assert exactly one clk.
  - Latency: the output is high in the cycle after the 3rd rising clk edge following the btn_in change.
- States: IDLE, HELD, LONG.
- IDLE:
  - cnt held at 0.
  - rise: press = 1, go to HELD.
- HELD:
  - Each tick_1ms: cnt += 1.
  - On the tick where cnt == LONG_MS-1: long_press = 1, cnt = 0, go to LONG.
- LONG:
  - Each tick_1ms: cnt += 1.
  - On the tick where cnt == REPEAT_MS-1: repeat_evt = 1, cnt = 0.
  - First repeat fires REPEAT_MS ticks after long_press.
- fall in HELD or LONG: release = 1, cnt = 0, go to IDLE.
- Priorities and boundaries:
  - fall and tick in the same cycle: fall wins; no long_press/repeat_evt that cycle.
  - fall in IDLE: ignored.
  - rise in HELD/LONG: cannot occur (btn_d tracks btn_s); no action required.
  - Release before LONG_MS ticks: no long_press.
  - The first tick after press may arrive 0-1 ms after the press, so a long press spans (LONG_MS-1, LONG_MS] ms.
  - tick_1ms held high continuously: count every clk (simulation speed-up mode).
  - Counter never wraps; it is cleared on every match, fall and IDLE entry.
  - Button held high across reset release: sync flops start at 0, so one press pulse is generated 3 cycles after release. This is intended.
  - Reset asserted mid-hold: all outputs drop to 0 immediately. No release pulse is emitted.
- Only one of press/release/long_press/repeat_evt may be high in any cycle.

Decomposition:
- Shared package, key_event_pkg:
  - State encoding localparams: IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2.
  - Default timing constants LONG_MS_DEF and REPEAT_MS_DEF.
- One sub-module: sync_2ff (parameterised width, async active-low reset to 0). It is reused by other async button and switch inputs.

Test Plan (LONG_MS=4, REPEAT_MS=2, tick_1ms every 10 clk unless stated):
- Reset, then btn_in 0→1 at clk edge N → press high only in cycle N+3; held = 1 from N+3; no other pulse.
- Hold 2 ticks, then release → release one cycle 3 clk after the falling edge; long_press never asserted; held = 0; cnt = 0.
- Hold 10 ticks → long_press on the 4th tick after press; repeat_evt on ticks 6, 8, 10; release then yields exactly one release pulse.
- Align the fall's synchronized edge to the same cycle as the 4th tick → release = 1, long_press = 0, state IDLE.
- Assert rst_n = 0 mid-LONG → all outputs 0 asynchronously. Deassert with btn_in still 1 → one press pulse 3 cycles later; long_press after 4 more ticks.
- tick_1ms tied to 1, hold 8 clk after press → long_press at the 4th counting cycle, repeat_evt every 2 clk after.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and default timing for the key_event button front end.
package key_event_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LONG = 2'd2;

    localparam int unsigned LONG_MS_DEF   = 1000;
    localparam int unsigned REPEAT_MS_DEF = 200;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StHeld = HELD,
        StLong = LONG
    } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all zeros.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_event.sv
// Turns a debounced button level into one-cycle press/release/long-press/repeat pulses.
// The release pulse is named release_evt because "release" is a reserved word.
module key_event
    import key_event_pkg::*;
#(
    parameter int unsigned LONG_MS   = LONG_MS_DEF,
    parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1ms,
    input  logic btn_in,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

    logic       btn_s, btn_d, rise, fall;
    key_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_d, release_d, long_d, repeat_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (btn_s)
    );

    assign rise = btn_s & ~btn_d;
    assign fall = ~btn_s & btn_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) begin
                    press_d = 1'b1;
                    state_d = StHeld;
                end
            end
            StHeld: begin
                // fall outranks a coincident tick
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (tick_1ms) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StLong;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StLong: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (tick_1ms) begin
                    if (cnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_d       <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            btn_d       <= btn_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press       <= press_d;
            release_evt <= release_d;
            long_press  <= long_d;
            repeat_evt  <= repeat_d;
        end
    end

    assign held = (state_q != StIdle);

endmodule
